pipeline_sequencer: RTL
=======================

Name: pipeline_sequencer

Overview:
- Central controller for the fetch -> shift -> decode -> execute datapath.
- Owns the program counter and drives instruction-memory reads.
- Loads the instruction register and strobes the decode/execute stage.
- Issues general-purpose-register write enables, retires instructions, and halts on a HALT opcode or end of program.

Parameters:
ADDR_W, 5, width of program counter / instruction address / GPR write address
DATA_W, 32, instruction word width
PROG_LEN, 5, number of instructions in program; last valid pc = PROG_LEN-1 (1..2^ADDR_W)
HALT_OPCODE, 17'b10000010011011011, value of instr[31:15] that stops execution without writeback
CNT_W, 8, width of retired-instruction counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  pulse: begin execution from IDLE, or restart from HALT
stall  input  1  hold request from downstream datapath
imem_rd_en  output  1  instruction memory read strobe
imem_addr  output  ADDR_W  instruction memory address (= pc)
imem_rdata  input  DATA_W  instruction memory data, valid exactly 1 cycle after imem_rd_en
ir  output  DATA_W  instruction register to decode stage
exec_en  output  1  decode/execute stage enable
gpr_we  output  1  GPR write enable
gpr_waddr  output  ADDR_W  GPR write address (= pc)
pc  output  ADDR_W  program counter
busy  output  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
halted  output  1  high in HALT
retired  output  CNT_W  count of instructions completed through WRITEBACK

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT. The state register is the only source of the strobes; strobes are decoded from state.
- Reset (reset=0, asynchronous):
  - State -> IDLE; pc=0, ir=0, retired=0.
  - All strobes 0; busy=0, halted=0.
  - Reset asserted mid-instruction abandons it with no writeback.
- IDLE: all strobes 0. start=1 -> FETCH; otherwise stay.
- FETCH (1 cycle): imem_rd_en=1, imem_addr=pc. Unconditionally -> DECODE.
- DECODE (1 cycle): ir <= imem_rdata at end of cycle. Unconditionally -> EXECUTE.
- EXECUTE:
  - exec_en=1.
  - If ir[31:15]==HALT_OPCODE -> HALT; pc and retired unchanged, no writeback. HALT takes priority over stall.
  - Else if stall=1, stay in EXECUTE with exec_en held high.
  - Else -> WRITEBACK.
- WRITEBACK:
  - gpr_we=1, gpr_waddr=pc.
  - If stall=1, stay with gpr_we held high (repeated write of same data is legal).
  - Else: retired increments, saturating at 2^CNT_W-1.
    - pc==PROG_LEN-1: pc unchanged -> HALT.
    - Otherwise pc <= pc+1 -> FETCH.
- HALT: halted=1, all strobes 0. start=1 -> pc<=0, ir unchanged, retired unchanged -> FETCH.
- start in any state other than IDLE/HALT is ignored.
- stall is ignored outside EXECUTE/WRITEBACK.
- Unstalled throughput: 4 cycles per instruction, one instruction in flight.
- pc wraps modulo 2^ADDR_W arithmetically but never exceeds PROG_LEN-1 by construction.
- ir holds its value in every state except DECODE.

Optional Feature:
- Macro: PIPELINE_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit) and state STEP_WAIT.
  - An unstalled WRITEBACK that would go to FETCH goes to STEP_WAIT instead, with pc already incremented.
  - STEP_WAIT: busy=1, all strobes 0. step=1 -> FETCH.
  - A step pulse arriving in the same cycle as WRITEBACK is not remembered.
  - The HALT paths are unchanged.
- When undefined: no step port and no STEP_WAIT; behaviour exactly as above.

Test Plan:
- Reset/idle: reset low mid-EXECUTE, then released -> next cycle state IDLE, pc=0, ir=0, retired=0, all strobes 0, busy=0.
- Straight run: PROG_LEN=5, memory words with non-HALT opcodes, one start pulse:
  - imem_rd_en at pc=0..4 every 4 cycles.
  - gpr_we with gpr_waddr=0..4.
  - halted=1 after 20 cycles with retired=5 and pc=4.
- HALT opcode: word at address 2 has [31:15]=10000010011011011 -> gpr_we only for addresses 0,1; HALT from EXECUTE; retired=2, pc=2.
- Stall: stall=1 for 3 cycles during EXECUTE of pc=1, then 2 cycles during WRITEBACK -> exec_en high 4 cycles, gpr_we high 3 cycles; only one retired increment; pc=2 after release.
- Restart/ignored start: start pulsed during DECODE -> no effect. start in HALT -> pc=0, FETCH next cycle, retired continues from its prior value. Saturation check: CNT_W=2, run 5 instructions -> retired=3.
- Single step (macro defined): after WRITEBACK of pc=0, FSM sits in STEP_WAIT with pc=1 and no imem_rd_en for 10 cycles; step pulse -> imem_rd_en with imem_addr=1 next cycle.

Source files
------------

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_sequencer
//  Purpose  : Central controller for the fetch -> shift -> decode -> execute
//             datapath. Owns the program counter, issues instruction-memory
//             reads, loads the instruction register, strobes the execute
//             stage, drives GPR write enables, counts retired instructions
//             and halts on the HALT opcode or after the last program word.
//  Revision : 1.0 - initial release
//
//  Optional build macro: PIPELINE_SEQ_SINGLE_STEP_EN
//    Adds input step_i and state STEP_WAIT. After each retired instruction
//    that is not the last, the sequencer parks until step_i is seen high.
//
//  Ports
//    clk_i         in   1       clock, all state on rising edge
//    rst_ni        in   1       asynchronous active-low reset
//    start_i       in   1       start from IDLE / restart from HALT
//    stall_i       in   1       hold request (honoured in EXECUTE/WRITEBACK)
//    step_i        in   1       single-step release (macro builds only)
//    imem_rd_en_o  out  1       instruction memory read strobe
//    imem_addr_o   out  ADDR_W  instruction memory address (= pc)
//    imem_rdata_i  in   DATA_W  instruction word, valid 1 cycle after read
//    ir_o          out  DATA_W  instruction register
//    exec_en_o     out  1       decode/execute stage enable
//    gpr_we_o      out  1       GPR write enable
//    gpr_waddr_o   out  ADDR_W  GPR write address (= pc)
//    pc_o          out  ADDR_W  program counter
//    busy_o        out  1       an instruction is in flight
//    halted_o      out  1       sequencer is in HALT
//    retired_o     out  CNT_W   saturating retired-instruction count
// ============================================================================
module pipeline_sequencer #(
  parameter int          ADDR_W      = 5,
  parameter int          DATA_W      = 32,
  parameter int          PROG_LEN    = 5,
  parameter logic [16:0] HALT_OPCODE = 17'b10000010011011011,
  parameter int          CNT_W       = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stall_i,
`ifdef PIPELINE_SEQ_SINGLE_STEP_EN
  input  logic              step_i,
`endif
  output logic              imem_rd_en_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [DATA_W-1:0] ir_o,
  output logic              exec_en_o,
  output logic              gpr_we_o,
  output logic [ADDR_W-1:0] gpr_waddr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  retired_o
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
`ifdef PIPELINE_SEQ_SINGLE_STEP_EN
    , S_STEP_WAIT = 3'd6
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                is_halt_op;

  // Opcode field occupies the top 17 bits of the instruction word.
  assign is_halt_op = (ir_q[DATA_W-1 -: 17] == HALT_OPCODE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = imem_rdata_i;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        // HALT opcode wins over a stall request and retires nothing.
        if (is_halt_op)    state_d = S_HALT;
        else if (!stall_i) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (!stall_i) begin
          retired_d = (retired_q == CNT_MAX) ? retired_q : retired_q + CNT_W'(1);
          if (pc_q == LAST_PC) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
`ifdef PIPELINE_SEQ_SINGLE_STEP_EN
            // step_i seen during WRITEBACK is deliberately not latched.
            state_d = S_STEP_WAIT;
`else
            state_d = S_FETCH;
`endif
          end
        end
      end
      S_HALT: begin
        if (start_i) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
`ifdef PIPELINE_SEQ_SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (step_i) state_d = S_FETCH;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are pure decodes of the state register.
  assign imem_rd_en_o = (state_q == S_FETCH);
  assign exec_en_o    = (state_q == S_EXECUTE);
  assign gpr_we_o     = (state_q == S_WRITEBACK);
  assign halted_o     = (state_q == S_HALT);
`ifdef PIPELINE_SEQ_SINGLE_STEP_EN
  assign busy_o       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXECUTE) || (state_q == S_WRITEBACK) ||
                        (state_q == S_STEP_WAIT);
`else
  assign busy_o       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
`endif

  assign imem_addr_o  = pc_q;
  assign gpr_waddr_o  = pc_q;
  assign pc_o         = pc_q;
  assign ir_o         = ir_q;
  assign retired_o    = retired_q;

endmodule
`default_nettype wire
